prio_encoder_arb: RTL and testbench
===================================

// Module: prio_encoder_arb
// PURPOSE
//  Parametrised, registered successor to the 8:3 priority encoder. It latches requests from
//  N sources and picks a winner by fixed priority (index 0 highest) or round-robin.
//  The winner goes out as a binary index plus one-hot vector, under a valid/ready handshake.
//  Sits between request sources and a shared resource (bus, port, FIFO write side).
// PARAMETERS
//  N      8  number of requesters, >=1
//  MODE   0  0 = fixed priority (lowest index wins); 1 = round-robin
//  IDX_W  $clog2(N) (min 1)  width of grant_idx; derived, not overridden
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  req          in   N      request bits, sampled every cycle
//  grant_ready  in   1      consumer accepts the current grant
//  grant_valid  out  1      grant_idx/grant_oh hold a valid grant
//  grant_idx    out  IDX_W  binary index of the granted requester
//  grant_oh     out  N      one-hot form of grant_idx
//  pending      out  N      latched, not-yet-granted requests
//  busy         out  1      grant_valid | (|pending)
// BEHAVIOUR
//  - Reset (async, rst_n=0): grant_valid=0, grant_idx=0, grant_oh=0, pending=0, rr ptr=0,
//    FSM=IDLE. Takes effect immediately, mid-grant included; an in-flight grant is discarded.
//  - accept = grant_valid & grant_ready.
//  - mask = (grant_valid ? grant_oh : 0): req of the in-flight index is ignored while it is
//    valid, the accept cycle included.
//  - src = pending | (req & ~mask): candidate set for selection.
//  - FSM IDLE (grant_valid=0): if src!=0, load the winner of src and go to GRANT. Else stay.
//  - FSM GRANT (grant_valid=1), while !accept: grant_idx/grant_oh held bit-stable;
//    pending <= src.
//  - FSM GRANT, on accept: if src!=0, load the next winner and stay in GRANT (no bubble).
//    Else go to IDLE, grant_valid=0.
//  - Load: grant_idx/oh <= winner, grant_valid <= 1, pending <= src & ~winner_oh.
//  - Latency: req high at edge t -> grant_valid=1 after edge t+1 (one register stage).
//  - Fixed winner = lowest set index of src.
//  - RR winner = first set index of src scanning ptr, ptr+1, ... N-1, 0, ... ptr-1.
//  - RR ptr updates on accept only: ptr <= (grant_idx==N-1) ? 0 : grant_idx+1 (wrap).
//  - The RR selection made in the accept cycle uses the updated ptr.
//  - ptr is unused when MODE=0.
//  - grant_valid=0 forces grant_idx=0 and grant_oh=0. No X is ever driven; src=0 never grants.
//  - Holding req[i] high after its accept re-pends i. Fixed mode may then re-grant i
//    indefinitely; RR mode queues i behind all other pending requesters.
//  - N=1: grant_idx is constant 0; behaviour reduces to a single-slot request latch.
// TESTING
//  1. MODE=0, req=8'hA0 one cycle, grant_ready=1 -> grant_idx 5 (oh 8'h20), next cycle
//     idx 7 (8'h80), then grant_valid=0, pending=0.
//  2. Reset idle, req=0 for 20 cycles -> grant_valid=0, idx=0, oh=0, busy=0 throughout.
//  3. MODE=1, req=8'hFF held, ready=1 -> idx 0,1,2,...,7,0,1 on consecutive cycles,
//     no bubbles.
//  4. MODE=0, grant idx 3 valid, ready=0 for 3 cycles while req pulses 8'h01 then 8'h80
//     -> idx 3 stable, pending=8'h81; on accept -> idx 0, then idx 7.
//  5. MODE=1, grant idx 6 accepted (ptr=7), req=8'h81 pulse -> idx 7 then idx 0; ptr ends at 1.
//  6. rst_n low mid-GRANT with pending=8'h0C -> grant_valid, oh, pending=0 asynchronously;
//     after release with req=0, stays IDLE.

Source files
------------

// File: rtl/prio_encoder_arb.sv
// Registered N-way request arbiter: fixed-priority or round-robin winner selection,
// presented as binary index plus one-hot under a valid/ready handshake.
module prio_encoder_arb #(
    parameter  int N     = 8,
    parameter  int MODE  = 0,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             grant_ready,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N-1:0]     grant_oh,
    output logic [N-1:0]     pending,
    output logic             busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic             accept;
    logic [N-1:0]     mask;
    logic [N-1:0]     src;
    logic [IDX_W-1:0] next_ptr;
    logic [IDX_W-1:0] sel_ptr;
    logic [IDX_W-1:0] win_idx;
    logic [N-1:0]     win_oh;

    function automatic logic [IDX_W-1:0] pick_fixed(input logic [N-1:0] s);
        pick_fixed = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (s[i]) pick_fixed = IDX_W'(i);
        end
    endfunction

    // Scan ptr, ptr+1, ..., wrapping; the first set bit found wins.
    function automatic logic [IDX_W-1:0] pick_rr(input logic [N-1:0] s,
                                                 input logic [IDX_W-1:0] p);
        logic         found;
        int           j;
        logic [N-1:0] sh;
        pick_rr = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(p) + k;
            if (j >= N) j = j - N;
            sh = s >> j;
            if (!found && sh[0]) begin
                found   = 1'b1;
                pick_rr = IDX_W'(j);
            end
        end
    endfunction

    always_comb begin
        accept   = grant_valid & grant_ready;
        mask     = grant_valid ? grant_oh : '0;
        src      = pending | (req & ~mask);
        next_ptr = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        sel_ptr  = accept ? next_ptr : ptr;
        win_idx  = (MODE == 1) ? pick_rr(src, sel_ptr) : pick_fixed(src);
        win_oh   = N'(1) << win_idx;
    end

    assign busy = grant_valid | (|pending);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            grant_oh    <= '0;
            pending     <= '0;
            ptr         <= '0;
        end else begin
            if (accept && MODE == 1) ptr <= next_ptr;
            case (state)
                IDLE: begin
                    if (src != '0) begin
                        state       <= GRANT;
                        grant_valid <= 1'b1;
                        grant_idx   <= win_idx;
                        grant_oh    <= win_oh;
                        pending     <= src & ~win_oh;
                    end else begin
                        pending     <= '0;
                    end
                end
                GRANT: begin
                    if (!accept) begin
                        pending <= src;
                    end else if (src != '0) begin
                        // Back-to-back grant: no idle bubble between winners.
                        grant_idx <= win_idx;
                        grant_oh  <= win_oh;
                        pending   <= src & ~win_oh;
                    end else begin
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                        grant_idx   <= '0;
                        grant_oh    <= '0;
                        pending     <= '0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant_valid <= 1'b0;
                    grant_idx   <= '0;
                    grant_oh    <= '0;
                    pending     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_encoder_arb.sv
// Directed bench for prio_encoder_arb: one fixed-priority and one round-robin instance
// share stimulus; each scenario checks the instance it targets.
module tb_prio_encoder_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       grant_ready = 1'b0;

    logic       v0, v1, b0, b1;
    logic [2:0] i0, i1;
    logic [7:0] oh0, oh1, p0, p1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    prio_encoder_arb #(.N(8), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .grant_ready(grant_ready),
        .grant_valid(v0), .grant_idx(i0), .grant_oh(oh0), .pending(p0), .busy(b0)
    );

    prio_encoder_arb #(.N(8), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .grant_ready(grant_ready),
        .grant_valid(v1), .grant_idx(i1), .grant_oh(oh1), .pending(p1), .busy(b1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 8'h00;
        grant_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if ({v0, i0, oh0, p0, b0} !== 20'h0) begin
            bad++;
            $display("FAIL reset_fixed got v=%b idx=%0d oh=%h pend=%h busy=%b want all 0", v0, i0, oh0, p0, b0);
        end
        total++;
        if ({v1, i1, oh1, p1, b1} !== 20'h0) begin
            bad++;
            $display("FAIL reset_rr got v=%b idx=%0d oh=%h pend=%h busy=%b want all 0", v1, i1, oh1, p1, b1);
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step();
            total++;
            if (v0 !== 1'b0 || i0 !== 3'd0 || oh0 !== 8'h00 || b0 !== 1'b0) begin
                bad++;
                $display("FAIL idle_c%0d got v=%b idx=%0d oh=%h busy=%b want 0 0 00 0", c, v0, i0, oh0, b0);
            end
        end
    endtask

    task automatic test_fixed_two();
        do_reset();
        req = 8'hA0;
        grant_ready = 1'b1;
        step();
        req = 8'h00;
        total++;
        if (v0 !== 1'b1 || i0 !== 3'd5 || oh0 !== 8'h20 || p0 !== 8'h80) begin
            bad++;
            $display("FAIL fixed_first got v=%b idx=%0d oh=%h pend=%h want 1 5 20 80", v0, i0, oh0, p0);
        end
        step();
        total++;
        if (v0 !== 1'b1 || i0 !== 3'd7 || oh0 !== 8'h80 || p0 !== 8'h00) begin
            bad++;
            $display("FAIL fixed_second got v=%b idx=%0d oh=%h pend=%h want 1 7 80 00", v0, i0, oh0, p0);
        end
        step();
        total++;
        if (v0 !== 1'b0 || i0 !== 3'd0 || oh0 !== 8'h00 || p0 !== 8'h00 || b0 !== 1'b0) begin
            bad++;
            $display("FAIL fixed_done got v=%b idx=%0d oh=%h pend=%h busy=%b want 0 0 00 00 0", v0, i0, oh0, p0, b0);
        end
    endtask

    task automatic test_rr_sweep();
        logic [2:0] exp_idx [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
        logic [7:0] exp_oh;
        do_reset();
        req = 8'hFF;
        grant_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            exp_oh = 8'h01 << exp_idx[c];
            total++;
            if (v1 !== 1'b1 || i1 !== exp_idx[c] || oh1 !== exp_oh) begin
                bad++;
                $display("FAIL rr_sweep_c%0d got v=%b idx=%0d oh=%h want 1 %0d %h", c, v1, i1, oh1, exp_idx[c], exp_oh);
            end
        end
        req = 8'h00;
        grant_ready = 1'b0;
    endtask

    task automatic test_fixed_hold();
        do_reset();
        req = 8'h08;
        grant_ready = 1'b0;
        step();
        req = 8'h01;
        total++;
        if (v0 !== 1'b1 || i0 !== 3'd3 || oh0 !== 8'h08) begin
            bad++;
            $display("FAIL hold_load got v=%b idx=%0d oh=%h want 1 3 08", v0, i0, oh0);
        end
        step();
        req = 8'h80;
        step();
        req = 8'h00;
        step();
        total++;
        if (v0 !== 1'b1 || i0 !== 3'd3 || oh0 !== 8'h08 || p0 !== 8'h81) begin
            bad++;
            $display("FAIL hold_stable got v=%b idx=%0d oh=%h pend=%h want 1 3 08 81", v0, i0, oh0, p0);
        end
        grant_ready = 1'b1;
        step();
        total++;
        if (v0 !== 1'b1 || i0 !== 3'd0 || oh0 !== 8'h01 || p0 !== 8'h80) begin
            bad++;
            $display("FAIL hold_acc0 got v=%b idx=%0d oh=%h pend=%h want 1 0 01 80", v0, i0, oh0, p0);
        end
        step();
        total++;
        if (v0 !== 1'b1 || i0 !== 3'd7 || oh0 !== 8'h80 || p0 !== 8'h00) begin
            bad++;
            $display("FAIL hold_acc7 got v=%b idx=%0d oh=%h pend=%h want 1 7 80 00", v0, i0, oh0, p0);
        end
        step();
        total++;
        if (v0 !== 1'b0 || b0 !== 1'b0) begin
            bad++;
            $display("FAIL hold_end got v=%b busy=%b want 0 0", v0, b0);
        end
        grant_ready = 1'b0;
    endtask

    task automatic test_rr_wrap();
        do_reset();
        req = 8'h40;
        grant_ready = 1'b1;
        step();
        total++;
        if (v1 !== 1'b1 || i1 !== 3'd6) begin
            bad++;
            $display("FAIL rr_wrap_6 got v=%b idx=%0d want 1 6", v1, i1);
        end
        req = 8'h81;
        step();
        req = 8'h00;
        total++;
        if (v1 !== 1'b1 || i1 !== 3'd7 || oh1 !== 8'h80 || p1 !== 8'h01) begin
            bad++;
            $display("FAIL rr_wrap_7 got v=%b idx=%0d oh=%h pend=%h want 1 7 80 01", v1, i1, oh1, p1);
        end
        step();
        total++;
        if (v1 !== 1'b1 || i1 !== 3'd0 || oh1 !== 8'h01) begin
            bad++;
            $display("FAIL rr_wrap_0 got v=%b idx=%0d oh=%h want 1 0 01", v1, i1, oh1);
        end
        step();
        total++;
        if (v1 !== 1'b0) begin
            bad++;
            $display("FAIL rr_wrap_idle got v=%b want 0", v1);
        end
        // Pointer now 1, so requester 1 must beat requester 0.
        req = 8'h03;
        step();
        req = 8'h00;
        total++;
        if (v1 !== 1'b1 || i1 !== 3'd1) begin
            bad++;
            $display("FAIL rr_ptr_1 got v=%b idx=%0d want 1 1", v1, i1);
        end
        step();
        total++;
        if (v1 !== 1'b1 || i1 !== 3'd0) begin
            bad++;
            $display("FAIL rr_ptr_next got v=%b idx=%0d want 1 0", v1, i1);
        end
        grant_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'h0D;
        grant_ready = 1'b0;
        step();
        req = 8'h00;
        total++;
        if (v0 !== 1'b1 || i0 !== 3'd0 || p0 !== 8'h0C) begin
            bad++;
            $display("FAIL areset_pre got v=%b idx=%0d pend=%h want 1 0 0C", v0, i0, p0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (v0 !== 1'b0 || oh0 !== 8'h00 || p0 !== 8'h00 || i0 !== 3'd0 || b0 !== 1'b0) begin
            bad++;
            $display("FAIL areset_now got v=%b idx=%0d oh=%h pend=%h busy=%b want 0 0 00 00 0", v0, i0, oh0, p0, b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            total++;
            if (v0 !== 1'b0 || p0 !== 8'h00 || b0 !== 1'b0) begin
                bad++;
                $display("FAIL areset_idle_c%0d got v=%b pend=%h busy=%b want 0 00 0", c, v0, p0, b0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_fixed_two();
        test_rr_sweep();
        test_fixed_hold();
        test_rr_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
